pipeline_sequencer: RTL
=======================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk in, rst in.
REQ-002 The block SHALL have these inputs:
- RS1_D, RS2_D (5 bits): decode-stage source register numbers.
- RD_E (5 bits): execute-stage destination register.
- RegWriteE, ResultSrcE (1 bit each): execute-stage write enable; ResultSrcE=1 means load.
- PCSrcE (1 bit): branch taken in execute.
- HaltReq, StepReq, ResumeReq (1 bit each): debug requests, each level-sampled on clk.
REQ-003 The block SHALL have these outputs:
- StallF, StallD (1 bit each): hold the PC and the IF/ID register.
- FlushD, FlushE (1 bit each): bubble the IF/ID and ID/EX registers.
- Halted (1 bit): state is HALT.
- State (2 bits): current sequencer state.

Function
REQ-004 The FSM SHALL have four states: RUN=0, DRAIN=1, HALT=2, STEP=3.
REQ-005 Load-use SHALL be detected when ResultSrcE=1, RegWriteE=1, RD_E!=0 and RD_E equals RS1_D or RS2_D.
REQ-006 In RUN with load-use and PCSrcE=0, the block SHALL assert StallF=1, StallD=1 and FlushE=1 in the same cycle (combinational, zero latency).
REQ-007 In RUN with PCSrcE=1, the block SHALL assert FlushD=1 and FlushE=1 with StallF=StallD=0; PCSrcE SHALL take priority over load-use.
REQ-008 In RUN with HaltReq=1, the block SHALL still apply REQ-006/007 that cycle and go to DRAIN on the next edge, loading drain counter=4.
REQ-009 In DRAIN, the block SHALL assert StallF=1 and FlushD=1 each cycle and decrement the counter. When the counter reaches 1, the next state SHALL be HALT.
REQ-010 In DRAIN with load-use, the block SHALL assert StallD=1 and FlushE=1, and the counter SHALL NOT decrement.
REQ-011 In DRAIN with PCSrcE=1, the block SHALL assert StallF=0 (the PC loads the target), FlushD=1 and FlushE=1, and reload the counter to 4.
REQ-012 In HALT, the block SHALL assert StallF=1, StallD=1, FlushE=1 and Halted=1.
REQ-013 In HALT, requests SHALL be resolved in this order:
- ResumeReq=1 SHALL go to RUN.
- Otherwise StepReq=1 SHALL go to STEP.
- HaltReq SHALL be ignored.
REQ-014 STEP SHALL last exactly one cycle. All four control outputs SHALL be 0 (one instruction advances F to D), then the block SHALL go to DRAIN with counter=4.
REQ-015 HaltReq, StepReq and ResumeReq SHALL be ignored in DRAIN and STEP.
REQ-016 The drain counter SHALL be 3 bits and SHALL never underflow.

Reset
REQ-017 While rst=0, the block SHALL hold State=RUN and counter=0, and drive all outputs to 0 regardless of the other inputs.
REQ-018 Deasserting rst mid-DRAIN SHALL resume in RUN, with no remembered halt.

Configuration
REQ-019 With PERF_COUNTERS_EN defined, the block SHALL add the following ports:
- ClearCnt (1-bit input).
- StallCount (32-bit output): increments each cycle REQ-006 or REQ-010 asserts StallD.
- FlushCount (32-bit output): increments each cycle PCSrcE=1 causes a flush.
REQ-020 With PERF_COUNTERS_EN defined, both counters SHALL saturate at 0xFFFFFFFF. ClearCnt=1 SHALL zero them on the next edge and take priority over increment. Reset SHALL zero them.
REQ-021 Without PERF_COUNTERS_EN, the ports and registers of REQ-019/020 SHALL be absent, and the behaviour of every other requirement SHALL be unchanged.

Structure
REQ-022 Shared package cpu_ctrl_pkg SHALL hold the seq_state_t enum (2 bits, values per REQ-004) and the constant DRAIN_CYCLES=4.
REQ-023 The load-use comparator (REQ-005) SHALL be the sub-module hazard_detect, purely combinational; FSM and counters SHALL live in pipeline_sequencer.

Verification
REQ-024 Load-use: RD_E=5, ResultSrcE=1, RegWriteE=1, RS2_D=5 in RUN -> StallF=StallD=FlushE=1 that cycle, all 0 the next cycle once the inputs clear.
REQ-025 Priority and x0: the REQ-024 inputs with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0; separately RD_E=0 matching RS1_D=0 -> no stall.
REQ-026 Halt: HaltReq pulse in RUN -> State=DRAIN for 4 cycles with StallF=FlushD=1, then HALT with Halted=1; a load-use in drain cycle 1 -> Halted one cycle later.
REQ-027 Step: StepReq in HALT -> 1 cycle STEP with outputs 0, 4 cycles DRAIN, then HALT; StepReq and ResumeReq together -> RUN.
REQ-028 Reset: drop rst during DRAIN count=2 -> outputs 0 immediately, State=RUN after release.
REQ-029 PERF_COUNTERS_EN: 3 load-use cycles and 2 taken branches -> StallCount=3, FlushCount=2; ClearCnt -> both 0 next edge; forcing 0xFFFFFFFF and stalling -> count holds.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the pipeline sequencer: state
// encoding, drain length and a saturating counter helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2,
    STEP  = 2'd3
  } seq_state_t;

  localparam int unsigned DRAIN_CYCLES = 4;
  localparam logic [2:0]  DRAIN_LOAD   = 3'(DRAIN_CYCLES);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Pipeline <-> sequencer control bundle. The pipeline side (master) drives
// hazard and debug-request inputs; the sequencer side (slave) returns the
// stall/flush controls and its state.
interface pipeline_sequencer_if;
  logic [4:0] RS1_D;
  logic [4:0] RS2_D;
  logic [4:0] RD_E;
  logic       RegWriteE;
  logic       ResultSrcE;
  logic       PCSrcE;
  logic       HaltReq;
  logic       StepReq;
  logic       ResumeReq;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic       Halted;
  logic [1:0] State;

  modport master (
    output RS1_D, RS2_D, RD_E, RegWriteE, ResultSrcE, PCSrcE,
           HaltReq, StepReq, ResumeReq,
    input  StallF, StallD, FlushD, FlushE, Halted, State
  );

  modport slave (
    input  RS1_D, RS2_D, RD_E, RegWriteE, ResultSrcE, PCSrcE,
           HaltReq, StepReq, ResumeReq,
    output StallF, StallD, FlushD, FlushE, Halted, State
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in execute whose destination (never x0)
// matches either decode-stage source operand. Purely combinational.
module hazard_detect (
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  input  logic       i_regwrite,
  input  logic       i_resultsrc,
  output logic       o_load_use
);

  logic w_rd_nonzero;
  logic w_match;

  assign w_rd_nonzero = (i_rd != 5'd0);
  assign w_match      = (i_rd == i_rs1) || (i_rd == i_rs2);
  assign o_load_use   = i_resultsrc && i_regwrite && w_rd_nonzero && w_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: hazard stall/flush generation plus a debug
// RUN/DRAIN/HALT/STEP state machine. Defining PERF_COUNTERS_EN adds
// saturating stall/flush event counters with a synchronous clear.
module pipeline_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  pipeline_sequencer_if.slave  bus
`ifdef PERF_COUNTERS_EN
  ,
  input  logic                 ClearCnt,
  output logic [31:0]          StallCount,
  output logic [31:0]          FlushCount
`endif
);

  seq_state_t r_state;
  seq_state_t w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_next_cnt;

  logic w_load_use;
  logic w_stall_f;
  logic w_stall_d;
  logic w_flush_d;
  logic w_flush_e;
  logic w_halted;
  logic w_stall_evt;
  logic w_flush_evt;

  hazard_detect u_hazard (
    .i_rs1       (bus.RS1_D),
    .i_rs2       (bus.RS2_D),
    .i_rd        (bus.RD_E),
    .i_regwrite  (bus.RegWriteE),
    .i_resultsrc (bus.ResultSrcE),
    .o_load_use  (w_load_use)
  );

  // State and drain-counter registers; reset always lands in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state, drain-count and stall/flush decode for the current state.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_halted     = 1'b0;
    w_stall_evt  = 1'b0;
    w_flush_evt  = 1'b0;
    case (r_state)
      RUN: begin
        // A taken branch squashes the dependent instruction anyway, so it
        // outranks the load-use stall.
        if (bus.PCSrcE) begin
          w_flush_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_flush_evt = 1'b1;
        end else if (w_load_use) begin
          w_stall_f   = 1'b1;
          w_stall_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_stall_evt = 1'b1;
        end
        if (bus.HaltReq) begin
          w_next_state = DRAIN;
          w_next_cnt   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // Stop fetching and let the instructions already in flight retire.
        w_stall_f = 1'b1;
        w_flush_d = 1'b1;
        if (bus.PCSrcE) begin
          w_stall_f   = 1'b0;
          w_flush_e   = 1'b1;
          w_flush_evt = 1'b1;
          w_next_cnt  = DRAIN_LOAD;
        end else if (w_load_use) begin
          w_stall_d   = 1'b1;
          w_flush_e   = 1'b1;
          w_stall_evt = 1'b1;
        end else if (r_cnt <= 3'd1) begin
          w_next_state = HALT;
          w_next_cnt   = 3'd0;
        end else begin
          w_next_cnt = r_cnt - 3'd1;
        end
      end
      HALT: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
        w_halted  = 1'b1;
        if (bus.ResumeReq) begin
          w_next_state = RUN;
        end else if (bus.StepReq) begin
          w_next_state = STEP;
        end
      end
      STEP: begin
        w_next_state = DRAIN;
        w_next_cnt   = DRAIN_LOAD;
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held.
  assign bus.StallF = rst & w_stall_f;
  assign bus.StallD = rst & w_stall_d;
  assign bus.FlushD = rst & w_flush_d;
  assign bus.FlushE = rst & w_flush_e;
  assign bus.Halted = rst & w_halted;
  assign bus.State  = rst ? r_state : 2'b00;

`ifdef PERF_COUNTERS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating event counters; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (ClearCnt) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall_evt) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_flush_evt) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`endif

endmodule
